// File: rtl/nios_cpu_div_pkg.sv
// rtl/nios_cpu_div_pkg.sv - shared types and constants for the Nios A-stage divider
package nios_CPU_div_pkg;

  localparam int DIV_W = 32;
  localparam int DIV_CYCLES = 32;
  localparam logic [DIV_W-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } div_state_e;

  function automatic logic [DIV_W-1:0] div_abs(input logic [DIV_W-1:0] v, input logic en);
    return (en && v[DIV_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/nios_cpu_div_step.sv
// rtl/nios_cpu_div_step.sv - one combinational radix-2 restoring division step
module nios_CPU_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic         dvd_msb,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] next_rem,
  output logic         quot_bit
);

  logic [W:0]   shifted;
  logic [W+1:0] trial;

  // rem < divisor always holds, so the shifted value fits W+1 bits and the extra bit carries the sign
  assign shifted  = {rem, dvd_msb};
  assign trial    = {1'b0, shifted} - {2'b00, divisor};
  assign quot_bit = ~trial[W+1];
  assign next_rem = quot_bit ? trial[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/nios_cpu_div_cell.sv
// rtl/nios_cpu_div_cell.sv - iterative 32-bit divider; signed mode under NIOS_CPU_DIV_SIGNED_EN
module nios_cpu_div_cell
  import nios_CPU_div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              A_div_start,
  input  logic              A_div_signed,
  input  logic [DATA_W-1:0] A_div_src1,
  input  logic [DATA_W-1:0] A_div_src2,
  output logic              A_div_busy,
  output logic              A_div_done,
  output logic [DATA_W-1:0] A_div_quot,
  output logic [DATA_W-1:0] A_div_rem
);

  localparam int CNT_W = $clog2(DIV_CYCLES);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rem_q, dvd_q, dvs_q;
  logic              zero_q, done_q;
  logic [DATA_W-1:0] quot_q, rem_out_q;
  logic [DATA_W-1:0] src1_abs, src2_abs, fix_quot, fix_rem;
  logic [DATA_W-1:0] step_rem;
  logic              step_bit;
  logic              accept;

  assign accept = (state_q == S_IDLE) && A_div_start;

`ifdef NIOS_CPU_DIV_SIGNED_EN
  logic sign_q, sign_r;

  assign src1_abs = div_abs(A_div_src1, A_div_signed);
  assign src2_abs = div_abs(A_div_src2, A_div_signed);
  assign fix_quot = sign_q ? -dvd_q : dvd_q;
  assign fix_rem  = sign_r ? -rem_q : rem_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else if (accept) begin
      sign_q <= A_div_signed & (A_div_src1[DATA_W-1] ^ A_div_src2[DATA_W-1]);
      sign_r <= A_div_signed & A_div_src1[DATA_W-1];
    end
  end
`else
  logic unused_signed;

  assign unused_signed = A_div_signed;
  assign src1_abs = A_div_src1;
  assign src2_abs = A_div_src2;
  assign fix_quot = dvd_q;
  assign fix_rem  = rem_q;
`endif

  nios_CPU_div_step #(.W(DATA_W)) u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[DATA_W-1]),
    .divisor  (dvs_q),
    .next_rem (step_rem),
    .quot_bit (step_bit)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (A_div_start) state_d = S_CALC;
      S_CALC:  if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // A zero divisor leaves the remainder equal to the dividend naturally; only the quotient is forced
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      zero_q    <= 1'b0;
      done_q    <= 1'b0;
      quot_q    <= '0;
      rem_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (A_div_start) begin
            dvd_q  <= src1_abs;
            dvs_q  <= src2_abs;
            rem_q  <= '0;
            cnt_q  <= CNT_W'(DIV_CYCLES - 1);
            zero_q <= (A_div_src2 == '0);
          end
        end
        S_CALC: begin
          rem_q <= step_rem;
          dvd_q <= {dvd_q[DATA_W-2:0], step_bit};
          cnt_q <= cnt_q - 1'b1;
        end
        S_FIX: begin
          quot_q    <= zero_q ? DIV_ZERO_QUOT : fix_quot;
          rem_out_q <= fix_rem;
          done_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign A_div_busy = (state_q != S_IDLE);
  assign A_div_done = done_q;
  assign A_div_quot = quot_q;
  assign A_div_rem  = rem_out_q;

endmodule
